// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall/flush
//                controller: FSM state encoding, control-bundle struct and
//                helpers that build the standard control patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    localparam int RW_DEF     = 5;
    localparam int PERF_W_DEF = 32;

    typedef enum logic [1:0] {
        PSC_ST_RUN      = 2'd0,
        PSC_ST_MEM_WAIT = 2'd1,
        PSC_ST_MD_WAIT  = 2'd2
    } psc_state_e;

    // One bundle for every stage-register control pin the block drives.
    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic md_ack;
    } psc_ctrl_t;

    // Every stage advances, nothing flushed.
    function automatic psc_ctrl_t psc_all_en();
        psc_ctrl_t c;
        c           = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

    // Front end frozen while mul/div runs in EX; a bubble drains into MEM.
    function automatic psc_ctrl_t psc_md_hold();
        psc_ctrl_t c;
        c              = '0;
        c.ex_mem_en    = 1'b1;
        c.ex_mem_flush = 1'b1;
        c.mem_wb_en    = 1'b1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Stage-status inputs and stage-register control outputs of
//                the pipeline stall/flush controller. Signal suffixes are
//                from the controller's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int RW     = RW_DEF,
    parameter int PERF_W = PERF_W_DEF
);
    logic [RW-1:0]     id_rs1_i;
    logic [RW-1:0]     id_rs2_i;
    logic              id_rs1_re_i;
    logic              id_rs2_re_i;
    logic [RW-1:0]     ex_rd_i;
    logic              ex_is_load_i;
    logic              ex_br_taken_i;
    logic              md_start_i;
    logic              md_done_i;
    logic              mem_req_i;
    logic              mem_ack_i;
    logic              pc_en_o;
    logic              pc_sel_o;
    logic              if_id_en_o;
    logic              id_ex_en_o;
    logic              ex_mem_en_o;
    logic              mem_wb_en_o;
    logic              if_id_flush_o;
    logic              id_ex_flush_o;
    logic              ex_mem_flush_o;
    logic              md_ack_o;
    logic [PERF_W-1:0] stall_cnt_o;
    logic [PERF_W-1:0] flush_cnt_o;

    // Core side: reports stage status, receives control.
    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, ex_rd_i,
               ex_is_load_i, ex_br_taken_i, md_start_i, md_done_i,
               mem_req_i, mem_ack_i,
        input  pc_en_o, pc_sel_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
               mem_wb_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               md_ack_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, ex_rd_i,
               ex_is_load_i, ex_br_taken_i, md_start_i, md_done_i,
               mem_req_i, mem_ack_i,
        output pc_en_o, pc_sel_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
               mem_wb_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               md_ack_o, stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_det.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_det
//  Description : Combinational load-use detector. Flags when the load in EX
//                writes a non-zero register that the instruction in ID reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_det
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  wire logic [RW-1:0] id_rs1_i,
    input  wire logic [RW-1:0] id_rs2_i,
    input  wire logic          id_rs1_re_i,
    input  wire logic          id_rs2_re_i,
    input  wire logic [RW-1:0] ex_rd_i,
    input  wire logic          ex_is_load_i,
    output logic               loaduse_o
);
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load to it cannot create a hazard.
    always_comb begin
        rs1_hit   = id_rs1_re_i && (id_rs1_i == ex_rd_i);
        rs2_hit   = id_rs2_re_i && (id_rs2_i == ex_rd_i);
        loaduse_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end
endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Central pipeline control for the 5-stage core. Resolves
//                data-memory wait, multi-cycle mul/div, taken branch and
//                load-use hazards into per-stage enable/flush decisions.
//                Outputs are combinational from state and inputs.
//                Optional macro PIPE_STALL_CTRL_PERF_EN adds stall/flush
//                cycle counters; without it the counter ports read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int RW     = RW_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    pipe_stall_ctrl_if.slave   bus
);
    psc_state_e state_q;
    psc_state_e state_d;
    psc_ctrl_t  ctrl;
    logic       loaduse;
    logic       memstall;

    pipe_hazard_det #(
        .RW (RW)
    ) u_hazard_det (
        .id_rs1_i     (bus.id_rs1_i),
        .id_rs2_i     (bus.id_rs2_i),
        .id_rs1_re_i  (bus.id_rs1_re_i),
        .id_rs2_re_i  (bus.id_rs2_re_i),
        .ex_rd_i      (bus.ex_rd_i),
        .ex_is_load_i (bus.ex_is_load_i),
        .loaduse_o    (loaduse)
    );

    assign memstall = bus.mem_req_i & ~bus.mem_ack_i;

    // Next state and stage controls; reset forces every control low.
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        if (!rst_n_i) begin
            state_d = PSC_ST_RUN;
        end else begin
            case (state_q)
                PSC_ST_MD_WAIT: begin
                    if (memstall) begin
                        // Whole pipe frozen; ack withheld until memory completes.
                        ctrl = '0;
                    end else if (!bus.md_done_i) begin
                        ctrl = psc_md_hold();
                    end else begin
                        // Hazards are re-evaluated next cycle from RUN.
                        ctrl        = psc_all_en();
                        ctrl.md_ack = 1'b1;
                        state_d     = PSC_ST_RUN;
                    end
                end
                default: begin
                    // RUN and MEM_WAIT share rules: once memory completes,
                    // MEM_WAIT behaves exactly as RUN in the same cycle.
                    // An illegal encoding also lands here and recovers.
                    if (memstall) begin
                        ctrl    = '0;
                        state_d = PSC_ST_MEM_WAIT;
                    end else if (bus.md_start_i) begin
                        ctrl    = psc_md_hold();
                        state_d = PSC_ST_MD_WAIT;
                    end else if (bus.ex_br_taken_i) begin
                        ctrl             = psc_all_en();
                        ctrl.pc_sel      = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                        state_d          = PSC_ST_RUN;
                    end else if (loaduse) begin
                        ctrl             = psc_all_en();
                        ctrl.pc_en       = 1'b0;
                        ctrl.if_id_en    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                        state_d          = PSC_ST_RUN;
                    end else begin
                        ctrl    = psc_all_en();
                        state_d = PSC_ST_RUN;
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= PSC_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_en_o        = ctrl.pc_en;
    assign bus.pc_sel_o       = ctrl.pc_sel;
    assign bus.if_id_en_o     = ctrl.if_id_en;
    assign bus.id_ex_en_o     = ctrl.id_ex_en;
    assign bus.ex_mem_en_o    = ctrl.ex_mem_en;
    assign bus.mem_wb_en_o    = ctrl.mem_wb_en;
    assign bus.if_id_flush_o  = ctrl.if_id_flush;
    assign bus.id_ex_flush_o  = ctrl.id_ex_flush;
    assign bus.ex_mem_flush_o = ctrl.ex_mem_flush;
    assign bus.md_ack_o       = ctrl.md_ack;

`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d;
    logic              any_flush;

    // Counters wrap naturally at 2^PERF_W.
    always_comb begin
        any_flush   = ctrl.if_id_flush | ctrl.id_ex_flush | ctrl.ex_mem_flush;
        stall_cnt_d = stall_cnt_q + {{(PERF_W-1){1'b0}}, ~ctrl.pc_en};
        flush_cnt_d = flush_cnt_q + {{(PERF_W-1){1'b0}}, any_flush};
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl with directed
//                scenarios and randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected-pattern order: pc_en pc_sel if_id_en id_ex_en ex_mem_en
    // mem_wb_en if_id_fl id_ex_fl ex_mem_fl md_ack
    localparam logic [9:0] P_OFF  = 10'b0000000000;
    localparam logic [9:0] P_RUN  = 10'b1011110000;
    localparam logic [9:0] P_MD   = 10'b0000110010;
    localparam logic [9:0] P_BR   = 10'b1111111100;
    localparam logic [9:0] P_LU   = 10'b0001110100;
    localparam logic [9:0] P_ACK  = 10'b1011110001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.RW(5), .PERF_W(32)) bus ();

    pipe_stall_ctrl #(.RW(5), .PERF_W(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          m_busy = 1'b0;
    bit          nxt_busy;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    logic [9:0]  exp_o;

    function automatic logic [9:0] outs();
        return {bus.pc_en_o, bus.pc_sel_o, bus.if_id_en_o, bus.id_ex_en_o,
                bus.ex_mem_en_o, bus.mem_wb_en_o, bus.if_id_flush_o,
                bus.id_ex_flush_o, bus.ex_mem_flush_o, bus.md_ack_o};
    endfunction

    // Reference: a single "mul/div outstanding" flag plus the priority rules.
    task automatic model_eval();
        bit ms, lu;
        ms = bus.mem_req_i && !bus.mem_ack_i;
        lu = bus.ex_is_load_i && (bus.ex_rd_i != 0) &&
             ((bus.id_rs1_re_i && bus.id_rs1_i == bus.ex_rd_i) ||
              (bus.id_rs2_re_i && bus.id_rs2_i == bus.ex_rd_i));
        nxt_busy = m_busy;
        if (!rst_n)                  begin exp_o = P_OFF; nxt_busy = 1'b0; end
        else if (ms)                 exp_o = P_OFF;
        else if (m_busy) begin
            if (bus.md_done_i)       begin exp_o = P_ACK; nxt_busy = 1'b0; end
            else                     exp_o = P_MD;
        end
        else if (bus.md_start_i)     begin exp_o = P_MD; nxt_busy = 1'b1; end
        else if (bus.ex_br_taken_i)  exp_o = P_BR;
        else if (lu)                 exp_o = P_LU;
        else                         exp_o = P_RUN;
    endtask

    task automatic commit();
        if (!rst_n) begin
            m_busy = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            m_busy = nxt_busy;
            if (!exp_o[9]) m_stall++;
            if (|exp_o[3:1]) m_flush++;
        end
    endtask

    task automatic idle();
        bus.id_rs1_i = 5'd0; bus.id_rs2_i = 5'd0;
        bus.id_rs1_re_i = 1'b0; bus.id_rs2_re_i = 1'b0;
        bus.ex_rd_i = 5'd0; bus.ex_is_load_i = 1'b0; bus.ex_br_taken_i = 1'b0;
        bus.md_start_i = 1'b0; bus.md_done_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input bit re1,
                          input logic [4:0] rs2, input bit re2);
        bus.ex_is_load_i = 1'b1; bus.ex_rd_i = rd;
        bus.id_rs1_i = rs1; bus.id_rs1_re_i = re1;
        bus.id_rs2_i = rs2; bus.id_rs2_re_i = re2;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        idle(); rst_n = 1'b0; bus.md_done_i = 1'b1; bus.ex_br_taken_i = 1'b1;
        @(negedge clk); model_eval();
        n_chk++;
        if (outs() !== exp_o) begin
            n_fail++; $display("FAIL reset_outs got %b expected %b", outs(), exp_o);
        end
        commit();
        @(posedge clk); #1;
        idle(); rst_n = 1'b1;
        @(negedge clk); model_eval();
        n_chk++;
        if (outs() !== exp_o) begin
            n_fail++; $display("FAIL reset_run got %b expected %b", outs(), exp_o);
        end
        n_chk++;
        if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d/%0d expected 0/0",
                               bus.stall_cnt_o, bus.flush_cnt_o);
        end
        commit();
    endtask

    task automatic test_loaduse();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0: set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
                1: set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
                2: set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
                3: set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
                4: begin set_lu(5'd9, 5'd9, 1'b1, 5'd9, 1'b1); bus.ex_is_load_i = 1'b0; end
                default: ;
            endcase
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL loaduse step %0d got %b expected %b", i, outs(), exp_o);
            end
            commit();
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            idle();
            bus.ex_br_taken_i = (i != 2);
            if (i == 0) set_lu(5'd3, 5'd3, 1'b1, 5'd3, 1'b1);
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL branch step %0d got %b expected %b", i, outs(), exp_o);
            end
            commit();
        end
    endtask

    task automatic test_muldiv();
        int flushes = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            idle();
            bus.md_start_i = (i == 0) || (i == 10);
            bus.md_done_i  = (i == 33);
            if (i == 12) bus.ex_br_taken_i = 1'b1;
            @(negedge clk); model_eval();
            if (bus.ex_mem_flush_o === 1'b1) flushes++;
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL muldiv step %0d got %b expected %b", i, outs(), exp_o);
            end
            commit();
        end
        n_chk++;
        if (flushes !== 33) begin
            n_fail++; $display("FAIL muldiv_flush_cycles got %0d expected 33", flushes);
        end
    endtask

    task automatic test_memstall();
        int unsigned s0;
        s0 = m_stall;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            bus.mem_req_i = (i < 5);
            bus.mem_ack_i = (i == 4);
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL memstall step %0d got %b expected %b", i, outs(), exp_o);
            end
            if (i == 5) begin
                n_chk++;
                if (bus.stall_cnt_o !== (PERF ? m_stall : 0) || m_stall - s0 != 4) begin
                    n_fail++; $display("FAIL memstall_cnt got %0d expected %0d",
                                       bus.stall_cnt_o, PERF ? m_stall : 0);
                end
            end
            commit();
        end
    endtask

    task automatic test_md_memstall();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            idle();
            bus.md_start_i = (i == 0);
            bus.md_done_i  = (i >= 4 && i <= 7);
            bus.mem_req_i  = (i >= 4 && i <= 7);
            bus.mem_ack_i  = (i == 7);
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL md_memstall step %0d got %b expected %b", i, outs(), exp_o);
            end
            commit();
        end
    endtask

    task automatic test_reset_mid_md();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            idle();
            rst_n = (i != 6);
            bus.md_start_i = (i == 0);
            bus.md_done_i  = (i == 6);
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL reset_mid_md step %0d got %b expected %b", i, outs(), exp_o);
            end
            if (i == 7) begin
                n_chk++;
                if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
                    n_fail++; $display("FAIL reset_mid_md_cnt got %0d/%0d expected 0/0",
                                       bus.stall_cnt_o, bus.flush_cnt_o);
                end
            end
            commit();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst_n             = ($urandom_range(0, 99) >= 3);
            bus.id_rs1_i      = 5'($urandom_range(0, 3));
            bus.id_rs2_i      = 5'($urandom_range(0, 3));
            bus.id_rs1_re_i   = 1'($urandom_range(0, 1));
            bus.id_rs2_re_i   = 1'($urandom_range(0, 1));
            bus.ex_rd_i       = 5'($urandom_range(0, 3));
            bus.ex_is_load_i  = ($urandom_range(0, 99) < 40);
            bus.ex_br_taken_i = ($urandom_range(0, 99) < 20);
            bus.md_start_i    = ($urandom_range(0, 99) < 8);
            bus.md_done_i     = ($urandom_range(0, 99) < 30);
            bus.mem_req_i     = ($urandom_range(0, 99) < 30);
            bus.mem_ack_i     = ($urandom_range(0, 99) < 50);
            @(negedge clk); model_eval();
            n_chk++;
            if (outs() !== exp_o) begin
                n_fail++; $display("FAIL random cyc %0d got %b expected %b", i, outs(), exp_o);
            end
            n_chk++;
            if (bus.stall_cnt_o !== (PERF ? m_stall : 0) ||
                bus.flush_cnt_o !== (PERF ? m_flush : 0)) begin
                n_fail++; $display("FAIL random_cnt cyc %0d got %0d/%0d expected %0d/%0d", i,
                                   bus.stall_cnt_o, bus.flush_cnt_o,
                                   PERF ? m_stall : 0, PERF ? m_flush : 0);
            end
            commit();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_loaduse();
        test_branch();
        test_muldiv();
        test_memstall();
        test_md_memstall();
        test_reset_mid_md();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
